// File: rtl/nes_controller_responder_if.sv
// Pin-level bundle between an NES pad host (latch/clk/buttons driver) and the
// pad responder. Optional build macro: NES_TURBO_EN adds turbo_mask.
interface nes_controller_responder_if #(
    parameter int DATA_BITS = 8
);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    logic [DATA_BITS-1:0] buttons_in;
`ifdef NES_TURBO_EN
    logic [DATA_BITS-1:0] turbo_mask;
`endif
    logic                 nes_latch;
    logic                 nes_clk;
    logic                 nes_data;
    logic                 busy;
    logic                 frame_done;
    logic [IDX_W-1:0]     bit_index;

`ifdef NES_TURBO_EN
    modport master (
        output buttons_in, turbo_mask, nes_latch, nes_clk,
        input  nes_data, busy, frame_done, bit_index
    );
    modport slave (
        input  buttons_in, turbo_mask, nes_latch, nes_clk,
        output nes_data, busy, frame_done, bit_index
    );
`else
    modport master (
        output buttons_in, nes_latch, nes_clk,
        input  nes_data, busy, frame_done, bit_index
    );
    modport slave (
        input  buttons_in, nes_latch, nes_clk,
        output nes_data, busy, frame_done, bit_index
    );
`endif
endinterface

// File: rtl/nes_controller_responder.sv
// NES pad emulator: behaves like the pad's 4021 parallel-in/serial-out
// register. Latch and clock pins are asynchronous and synchronised here;
// every output is registered. DATA_BITS must be at least 2.
// Optional build macro: NES_TURBO_EN (turbo_mask with alternating frame phase).
module nes_controller_responder #(
    parameter int   DATA_BITS   = 8,
    parameter int   SYNC_STAGES = 2,
    parameter logic FILL_VALUE  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    nes_controller_responder_if.slave    pad
);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e state_q, state_d;

    // One extra flop beyond the synchroniser holds the previous level for edge detection.
    logic [SYNC_STAGES:0] latch_sync_q, latch_sync_d;
    logic [SYNC_STAGES:0] clk_sync_q, clk_sync_d;

    logic                 latch_s;
    logic                 latch_fall_s;
    logic                 clk_rise_s;
    logic                 last_bit_s;
    logic [DATA_BITS-1:0] load_val_s;

    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 nes_data_q, nes_data_d;
    logic                 busy_q, busy_d;
    logic                 frame_done_q, frame_done_d;
    logic [IDX_W-1:0]     bit_index_q, bit_index_d;

    assign latch_s      = latch_sync_q[SYNC_STAGES-1];
    assign latch_fall_s = latch_sync_q[SYNC_STAGES] & ~latch_sync_q[SYNC_STAGES-1];
    assign clk_rise_s   = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES];
    assign last_bit_s   = (bit_index_q == IDX_W'(DATA_BITS - 1));

    // Shift the raw pins into their synchroniser chains.
    always_comb begin
        latch_sync_d = {latch_sync_q[SYNC_STAGES-1:0], pad.nes_latch};
        clk_sync_d   = {clk_sync_q[SYNC_STAGES-1:0], pad.nes_clk};
    end

`ifdef NES_TURBO_EN
    logic phase_q, phase_d;

    // Turbo phase flips once per completed latch pulse.
    always_comb begin
        if (latch_fall_s) begin
            phase_d = ~phase_q;
        end else begin
            phase_d = phase_q;
        end
    end

    // Turbo phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Turbo buttons read as released on even phases.
    assign load_val_s = pad.buttons_in & ~(pad.turbo_mask & {DATA_BITS{~phase_q}});
`else
    assign load_val_s = pad.buttons_in;
`endif

    // State register and synchroniser flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            latch_sync_q <= '0;
            clk_sync_q   <= '0;
        end else begin
            state_q      <= state_d;
            latch_sync_q <= latch_sync_d;
            clk_sync_q   <= clk_sync_d;
        end
    end

    // Next-state logic: a high latch always wins over a clock edge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (latch_s) state_d = ST_LOAD;
                else         state_d = ST_IDLE;
            end
            ST_LOAD: begin
                if (latch_fall_s) state_d = ST_SHIFT;
                else              state_d = ST_LOAD;
            end
            ST_SHIFT: begin
                if (latch_s)                        state_d = ST_LOAD;
                else if (clk_rise_s && last_bit_s)  state_d = ST_DONE;
                else                                state_d = ST_SHIFT;
            end
            ST_DONE: begin
                if (latch_s) state_d = ST_LOAD;
                else         state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output values; loading follows state_d so the pin latency stays minimal.
    always_comb begin
        shreg_d     = shreg_q;
        bit_index_d = bit_index_q;
        if (state_d == ST_LOAD) begin
            shreg_d     = ~load_val_s;
            bit_index_d = '0;
        end else if ((state_q == ST_SHIFT) && clk_rise_s) begin
            shreg_d     = {FILL_VALUE, shreg_q[DATA_BITS-1:1]};
            bit_index_d = bit_index_q + IDX_W'(1);
        end else begin
            shreg_d     = shreg_q;
            bit_index_d = bit_index_q;
        end

        if ((state_d == ST_LOAD) || (state_d == ST_SHIFT)) begin
            nes_data_d = shreg_d[0];
        end else begin
            nes_data_d = FILL_VALUE;
        end

        busy_d       = (state_d == ST_SHIFT);
        frame_done_d = (state_q == ST_SHIFT) && (state_d == ST_DONE);
    end

    // Shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q      <= '1;
            nes_data_q   <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            bit_index_q  <= '0;
        end else begin
            shreg_q      <= shreg_d;
            nes_data_q   <= nes_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            bit_index_q  <= bit_index_d;
        end
    end

    assign pad.nes_data   = nes_data_q;
    assign pad.busy       = busy_q;
    assign pad.frame_done = frame_done_q;
    assign pad.bit_index  = bit_index_q;

endmodule
